// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the pulse burst generator.
// Imported by pulse_burst_gen and its testbench.
package pulse_gen_pkg;

  localparam int DIV_W_DEF = 26;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/period_divider.sv
// Reloading down-counter: ticks when it reaches zero while enabled,
// then reloads from value on the same edge.
module period_divider #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic         tick
);

  logic [W-1:0] cnt_q;

  assign tick = enable && (cnt_q == '0);

  // Count down while enabled; reload on explicit load or at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (enable) begin
      if (cnt_q == '0) cnt_q <= value;
      else             cnt_q <= cnt_q - W'(1);
    end
  end

endmodule

// File: rtl/pulse_burst_gen.sv
// Emits a burst of burst_len one-cycle pulses spaced period cycles apart.
// Define PULSE_BURST_GEN_CONT_EN to make burst_len=0 run until stopped.
module pulse_burst_gen
  import pulse_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] period,
  input  logic [CNT_W-1:0] burst_len,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] per_src;
  logic [DIV_W-1:0] reload;
  logic [CNT_W-1:0] left_q;
  logic             load;
  logic             div_en;
  logic             tick;

  assign load    = (state_q == IDLE) && start;
  assign div_en  = (state_q == RUN) && !stop;
  assign per_src = load ? period : period_q;
  assign reload  = (per_src == '0) ? '0 : per_src - DIV_W'(1);

  assign pulses_left = left_q;

  period_divider #(
    .W(DIV_W)
  ) u_div (
    .clk   (clk),
    .resetn(resetn),
    .load  (load),
    .value (reload),
    .enable(div_en),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state: start from IDLE, stop or last pulse ends RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
`ifdef PULSE_BURST_GEN_CONT_EN
          state_d = RUN;
`else
          state_d = (burst_len == '0) ? DONE : RUN;
`endif
        end
      end
      RUN: begin
        if (stop)
          state_d = IDLE;
        else if (tick && (left_q == CNT_W'(1)))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and divider tick.
  always_comb begin
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
    pulse = tick;
  end

  // Latch burst parameters on start; count pulses down, saturating.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period_q <= '0;
      left_q   <= '0;
    end else if (load) begin
      period_q <= period;
      left_q   <= burst_len;
    end else if (tick && (left_q != '0)) begin
      left_q   <= left_q - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen: burst timing, stop, reset,
// ignored restart, zero-length bursts.
module tb_pulse_burst_gen;
  import pulse_gen_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [25:0] period = '0;
  logic [3:0]  burst_len = '0;
  logic        pulse;
  logic        busy;
  logic        done;
  logic [3:0]  pulses_left;

  int          total = 0;
  int          bad = 0;
  logic [63:0] pm;
  logic [63:0] dm;
  int          bc;
  logic [3:0]  pla [0:63];
  logic [6:0]  snap;

  pulse_burst_gen dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .stop       (stop),
    .period     (period),
    .burst_len  (burst_len),
    .pulse      (pulse),
    .busy       (busy),
    .done       (done),
    .pulses_left(pulses_left)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Launch a burst: start is high during cycle T, returns in T+1.
  task automatic go(input logic [25:0] p, input logic [3:0] b);
    @(negedge clk);
    period    = p;
    burst_len = b;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Record outputs for cycles T+1..T+n with optional events.
  task automatic cap(input int n, input int stop_at,
                     input int rst_at, input int s2_at);
    pm = '0;
    dm = '0;
    bc = 0;
    snap = '1;
    for (int k = 1; k <= n; k++) begin
      if (k == stop_at) stop = 1'b1;
      if (k == stop_at + 1) stop = 1'b0;
      if (k == rst_at) resetn = 1'b0;
      if (k == rst_at + 2) resetn = 1'b1;
      if (k == s2_at) begin
        start = 1'b1;
        period = 26'd1;
        burst_len = 4'd15;
      end
      if (k == s2_at + 1) start = 1'b0;
      #1;
      pm[k] = pulse;
      dm[k] = done;
      bc += int'(busy);
      pla[k] = pulses_left;
      if (k == rst_at) snap = {pulse, busy, done, pulses_left};
      @(negedge clk);
    end
    stop = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pulse", 64'(pulse), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_left", 64'(pulses_left), 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // period 4, three pulses
    go(26'd4, 4'd3);
    cap(16, 0, 0, 0);
    chk("p4_pulse", pm, 64'h1110);
    chk("p4_done", dm, 64'h2000);
    chk("p4_busy", 64'(bc), 64'd12);
    chk("p4_left1", 64'(pla[1]), 64'd3);

    // period 0 acts as 1: back-to-back pulses
    go(26'd0, 4'd5);
    cap(10, 0, 0, 0);
    chk("p0_pulse", pm, 64'h3E);
    chk("p0_done", dm, 64'h40);
    for (int i = 0; i < 5; i++)
      chk("p0_left", 64'(pla[i+2]), 64'(4 - i));

    // stop after two pulses
    go(26'd10, 4'd4);
    cap(32, 25, 0, 0);
    chk("stop_pulse", pm, 64'h100400);
    chk("stop_done", dm, 64'd0);
    chk("stop_busy", 64'(bc), 64'd25);

    // reset mid-burst
    go(26'd3, 4'd2);
    cap(20, 0, 4, 0);
    chk("rst_snap", 64'(snap), 64'd0);
    chk("rst_pulse_m", pm, 64'h8);
    chk("rst_done_m", dm, 64'd0);
    chk("rst_busy_m", 64'(bc), 64'd3);

    // second start during RUN is ignored
    go(26'd6, 4'd2);
    cap(20, 0, 0, 3);
    chk("s2_pulse", pm, 64'h1040);
    chk("s2_done", dm, 64'h2000);
    chk("s2_busy", 64'(bc), 64'd12);
    chk("s2_left", 64'(pla[7]), 64'd1);

    // stop beats a coincident terminal pulse
    go(26'd2, 4'd1);
    cap(8, 2, 0, 0);
    chk("stopw_pulse", pm, 64'd0);
    chk("stopw_done", dm, 64'd0);
    chk("stopw_busy", 64'(bc), 64'd2);

    // stop in DONE is ignored
    go(26'd1, 4'd1);
    cap(6, 2, 0, 0);
    chk("stopd_pulse", pm, 64'h2);
    chk("stopd_done", dm, 64'h4);

    // zero-length burst
    go(26'd2, 4'd0);
    cap(12, 9, 0, 0);
`ifdef PULSE_BURST_GEN_CONT_EN
    chk("z_pulse", pm, 64'h154);
    chk("z_done", dm, 64'd0);
    chk("z_busy", 64'(bc), 64'd9);
    chk("z_left", 64'(pla[5]), 64'd0);
`else
    chk("z_pulse", pm, 64'd0);
    chk("z_done", dm, 64'h2);
    chk("z_busy", 64'(bc), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_burst_gen.md
PULSE_BURST_GEN -- requirements
Module: pulse_burst_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 26, giving the width of the period divider.
REQ-002 SHALL have parameter CNT_W, default 4, giving the width of the burst count.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request a burst; sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1 bit: abort a running burst.
REQ-007 SHALL have port period, input, DIV_W bits: clk cycles between pulses; latched on accepted start.
REQ-008 SHALL have port burst_len, input, CNT_W bits: number of pulses to emit; latched on accepted start.
REQ-009 SHALL have port pulse, output, 1 bit: one-cycle-wide pulse that drives the downstream wrapping counter's increment input.
REQ-010 SHALL have port busy, output, 1 bit: high in RUN.
REQ-011 SHALL have port done, output, 1 bit: one-cycle completion strobe.
REQ-012 SHALL have port pulses_left, output, CNT_W bits: pulses still to emit in the current burst.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE on last pulse, RUN->IDLE on stop, DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL, on start in IDLE, latch period and burst_len, load the divider with max(period,1)-1, set pulses_left=burst_len, and enter RUN the next cycle.
REQ-015 SHALL count the divider down by one per cycle in RUN, and on reaching 0 assert pulse for exactly one cycle and reload max(period,1)-1.
REQ-016 SHALL emit the first pulse max(period,1) cycles after the cycle in which start was accepted; period 0 behaves as period 1 (a pulse every cycle).
REQ-017 SHALL decrement pulses_left by one in the same cycle as each pulse, saturating at 0.
REQ-018 SHALL enter DONE in the cycle after the pulse that brings pulses_left to 0, and assert done=1 for that single DONE cycle.
REQ-019 SHALL ignore start while in RUN or DONE; latched period and burst_len do not change mid-burst.
REQ-020 SHALL, on stop in RUN, return to IDLE next cycle with no pulse and no done; stop wins over a coincident terminal pulse.
REQ-021 SHALL ignore stop in IDLE and in DONE.
REQ-022 SHALL treat start with burst_len=0 as an immediate completion (IDLE->DONE, no pulses), except as given by REQ-027.
REQ-023 SHALL drive busy=1 exactly in RUN; pulse and done are never high in the same cycle.

Reset
REQ-024 SHALL, on resetn=0, asynchronously force IDLE, pulse=0, busy=0, done=0, pulses_left=0, and divider=0.
REQ-025 SHALL, on reset asserted mid-burst, emit no further pulse or done; after release the block waits in IDLE for a new start.

Configuration
REQ-026 SHALL recognise the macro PULSE_BURST_GEN_CONT_EN.
REQ-027 SHALL, with PULSE_BURST_GEN_CONT_EN defined, treat burst_len=0 as continuous mode: RUN indefinitely, pulses_left held at 0, exit only via stop or reset, and never assert done.
REQ-028 SHALL, without PULSE_BURST_GEN_CONT_EN, follow REQ-022 and contain no continuous-mode logic.

Structure
REQ-029 SHALL take the state enum type (IDLE/RUN/DONE) and the default DIV_W and CNT_W constants from the shared package pulse_gen_pkg.
REQ-030 SHALL place the reloading down-counter in one sub-module, period_divider (inputs: load, value, enable; output: terminal tick).

Verification
REQ-031 SHALL cover this case: period=4, burst_len=3, start pulsed -> pulses 4, 8 and 12 cycles after the start cycle; done 13 cycles after it; busy high for 12 cycles.
REQ-032 SHALL cover this case: period=0, burst_len=5 -> 5 consecutive cycles with pulse=1; pulses_left goes 4,3,2,1,0; then one done cycle.
REQ-033 SHALL cover this case: period=10, burst_len=4, stop asserted 25 cycles after start -> exactly 2 pulses, no done, IDLE next cycle.
REQ-034 SHALL cover this case: period=3, burst_len=2, resetn low 4 cycles after start -> all outputs 0 immediately; no pulse or done after release until a new start.
REQ-035 SHALL cover this case: second start during RUN with period=1, burst_len=15 -> ignored; original period=6, burst_len=2 burst completes unchanged.
REQ-036 SHALL cover this case: burst_len=0, period=2 -> without the macro, done one cycle after start and no pulse; with PULSE_BURST_GEN_CONT_EN, a pulse every 2 cycles until stop, and done never asserted.
